// File: rtl/trdb_qual_tracker.sv
// Qualification tracker: turns filter qualification edges and a retire-count resync timer
// into START/RESYNC/STOP packet requests. Resync logic is present only with TRDB_QUAL_RESYNC_EN.
module trdb_qual_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             nc_trace_qualified_i,
  input  logic             iretire_i,
  input  logic [CNT_W-1:0] resync_max_i,
  input  logic             pkt_ready_i,
  output logic             pkt_valid_o,
  output logic [1:0]       pkt_type_o,
  output logic             tracing_o
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StStartPend  = 3'd1;
  localparam logic [2:0] StTracing    = 3'd2;
  localparam logic [2:0] StResyncPend = 3'd3;
  localparam logic [2:0] StStopPend   = 3'd4;

  localparam logic [1:0] PktNone   = 2'd0;
  localparam logic [1:0] PktStart  = 2'd1;
  localparam logic [1:0] PktResync = 2'd2;
  localparam logic [1:0] PktStop   = 2'd3;

  logic [2:0] state_q, state_d;
  logic       stop_seen_q, stop_seen_d;

`ifdef TRDB_QUAL_RESYNC_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync_hit;

  // Compare one bit wider so cnt_q + 1 cannot wrap into a false match.
  assign resync_hit = (resync_max_i != '0) &&
                      (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, resync_max_i});
`else
  logic unused_resync_max;
  assign unused_resync_max = ^resync_max_i;
`endif

  always_comb begin
    state_d     = state_q;
    stop_seen_d = stop_seen_q;
`ifdef TRDB_QUAL_RESYNC_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (nc_trace_qualified_i && iretire_i) state_d = StStartPend;
      end
      StStartPend: begin
`ifdef TRDB_QUAL_RESYNC_EN
        cnt_d = '0;
`endif
        // A pending request is never withdrawn; a stop seen meanwhile follows it.
        if (pkt_ready_i) begin
          state_d     = stop_seen_q ? StStopPend : StTracing;
          stop_seen_d = 1'b0;
        end else if (!nc_trace_qualified_i) begin
          stop_seen_d = 1'b1;
        end
      end
      StTracing: begin
        if (!nc_trace_qualified_i) begin
          state_d = StStopPend;
        end else if (iretire_i) begin
`ifdef TRDB_QUAL_RESYNC_EN
          if (resync_hit) begin
            state_d = StResyncPend;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`endif
        end
      end
`ifdef TRDB_QUAL_RESYNC_EN
      StResyncPend: begin
        cnt_d = '0;
        if (pkt_ready_i) begin
          state_d     = stop_seen_q ? StStopPend : StTracing;
          stop_seen_d = 1'b0;
        end else if (!nc_trace_qualified_i) begin
          stop_seen_d = 1'b1;
        end
      end
`endif
      StStopPend: begin
        if (pkt_ready_i) state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        stop_seen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_seen_q <= stop_seen_d;
    end
  end

`ifdef TRDB_QUAL_RESYNC_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    pkt_valid_o = 1'b0;
    pkt_type_o  = PktNone;
    tracing_o   = 1'b0;
    case (state_q)
      StStartPend: begin
        pkt_valid_o = 1'b1;
        pkt_type_o  = PktStart;
        tracing_o   = 1'b1;
      end
      StTracing: begin
        tracing_o = 1'b1;
      end
      StResyncPend: begin
        pkt_valid_o = 1'b1;
        pkt_type_o  = PktResync;
        tracing_o   = 1'b1;
      end
      StStopPend: begin
        pkt_valid_o = 1'b1;
        pkt_type_o  = PktStop;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trdb_qual_tracker.md
# trdb_qual_tracker

Qualification tracker that sits directly downstream of the trace filter in the trace encoder. It consumes the filter's `nc_trace_qualified` decision and the core's instruction-retire strobe, and turns qualification edges and a periodic resync counter into a single stream of packet requests (START, RESYNC, STOP) with a valid/ready handshake. The packet emitter consumes these requests.

## Interface
Parameters:
- `CNT_W`, default 16: width of the resync instruction counter and of `resync_max_i`.

Ports:
- `clk_i`  in  1: clock; single clock domain.
- `rst_ni`  in  1: reset; asynchronous, active-low.
- `nc_trace_qualified_i`  in  1: qualification from the filter stage.
- `iretire_i`  in  1: one instruction retired this cycle.
- `resync_max_i`  in  CNT_W: retired-instruction count between RESYNC requests, from registers; 0 disables resync.
- `pkt_ready_i`  in  1: emitter accepts the current request.
- `pkt_valid_o`  out  1: request pending.
- `pkt_type_o`  out  2: 0 = none, 1 = START, 2 = RESYNC, 3 = STOP.
- `tracing_o`  out  1: trace session active.

## Operation
- FSM states: IDLE, START_PEND, TRACING, RESYNC_PEND, STOP_PEND.
- IDLE: if `nc_trace_qualified_i && iretire_i`, go to START_PEND. Qualification without a retire does nothing.
- START_PEND: on `pkt_ready_i`, go to TRACING, or to STOP_PEND if `stop_seen` is set. Counter cleared.
- TRACING:
  - `!nc_trace_qualified_i` goes to STOP_PEND. This has priority over resync in the same cycle.
  - Otherwise, each `iretire_i` increments the counter.
  - When `iretire_i` occurs with `cnt + 1 == resync_max_i` (compared at CNT_W+1 bits, no wrap) and `resync_max_i != 0`, go to RESYNC_PEND and clear the counter.
- RESYNC_PEND: counter frozen at 0. On `pkt_ready_i`, go to TRACING, or to STOP_PEND if `stop_seen` is set.
- STOP_PEND: on `pkt_ready_i`, go to IDLE. A re-qualification during STOP_PEND, or in the accept cycle, is ignored. A new START needs a qualified retire while in IDLE.
- `stop_seen`:
  - Set on any cycle with `!nc_trace_qualified_i` while in START_PEND or RESYNC_PEND.
  - Cleared on leaving those states.
  - Pending requests are never withdrawn; the stop is deferred until acceptance.
- Outputs:
  - `pkt_valid_o` = state ∈ {START_PEND, RESYNC_PEND, STOP_PEND}.
  - `pkt_type_o` is encoded from the state; it is 0 when valid is low.
  - `tracing_o` = state ∈ {START_PEND, TRACING, RESYNC_PEND}.
- Handshake:
  - Transfer occurs when `pkt_valid_o && pkt_ready_i`.
  - While valid is high and ready is low, `pkt_type_o` holds stable.
  - `pkt_ready_i` while valid is low is ignored.
- Changing `resync_max_i` mid-session takes effect at the next compare. If the new value ≤ the current count, no resync occurs until the counter wraps at 2^CNT_W. Wrap is plain modulo.

## Timing
- Reset (asynchronous, immediate on `rst_ni` low): state IDLE; `pkt_valid_o`, `pkt_type_o`, `tracing_o`, counter and `stop_seen` all 0. This holds mid-handshake too; any pending request is dropped.
- All outputs are registered state decodes; there is no combinational path from inputs to outputs.
- START: valid rises 1 cycle after the qualifying retire cycle.
- RESYNC: valid rises 1 cycle after the retire that hits the count.
- STOP: valid rises 1 cycle after qualification falls in TRACING. For deferred stops, valid rises the cycle after acceptance of the prior request, giving back-to-back requests with no gap.
- Accept cycle: valid drops the next cycle unless a follow-on request (deferred STOP) is queued.
- Retires in the accept cycle of START/RESYNC are not counted.

## Configuration
- `TRDB_QUAL_RESYNC_EN` defined: resync counter, RESYNC_PEND and type 2 are present, as above.
- Undefined:
  - Counter and RESYNC_PEND are removed.
  - `resync_max_i` is unused.
  - `pkt_type_o` never equals 2.
  - `stop_seen` applies only to START_PEND.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_ni`=0 with random inputs -> valid=0, type=0, tracing=0. Assert reset in RESYNC_PEND -> valid=0 in the same cycle.
- Start with backpressure: qualified=1, iretire pulse at cycle 10, ready=0 for cycles 11–13, ready=1 at cycle 14 -> valid=1/type=1 during cycles 11–14; tracing=1 from cycle 11; valid=0 at cycle 15.
- Resync: `resync_max_i`=4, ready=1 always; after START is accepted, 4 retires -> exactly one type=2 request the cycle after the 4th retire. A further 4 retires -> another one. `resync_max_i`=0 with 100 retires -> none.
- Stop: in TRACING, drop qualified at cycle 20 -> type=3 at cycle 21; after accept, tracing=0 and state IDLE. Re-qualifying with a retire -> new START.
- Deferred stop: drop qualified during START_PEND with ready=0; raise ready for 2 cycles -> START then STOP on consecutive cycles, then valid=0.
- Priority: in TRACING, a retire hitting the resync count in the same cycle as qualified falling -> STOP only, no RESYNC. With `TRDB_QUAL_RESYNC_EN` undefined, the resync scenario yields no type=2.
